slp_train_ctrl: RTL and testbench

Sequential training controller for the single-layer perceptron. It owns the weight register and accepts labelled samples over a valid/ready handshake. For each sample it captures the inference result from the external inference datapath, applies the gradient-descent update through an internal `slp_train` instance, and tracks epochs until convergence or an epoch limit. It sits between the sample source and the inference datapath, which reads `weight` and `cur_in` and returns `infer`.

---
 rtl/slp_train_ctrl_pkg.sv | 22 ++
 rtl/slp_train_ctrl_if.sv | 14 +
 rtl/slp_train_ctrl_slp_train.sv | 74 +++++++
 rtl/slp_train_ctrl.sv | 131 +++++++++++++
 tb/tb_slp_train_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slp_train_ctrl_pkg.sv
// Shared types for the perceptron training controller: data formats and controller states.
package slp_train_ctrl_pkg;

  typedef enum logic [1:0] {DT_INT, DT_FIX} dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF = '{dtype: DT_INT, prec: 8'd8, frac: 8'd0};

  typedef enum logic [2:0] {
    IDLE, WAIT_SMP, EVAL, UPDATE, EPOCH_END, DONE
  } slp_ctrl_state_t;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/slp_train_ctrl_if.sv
// Labelled-sample stream into the training controller.
interface slp_train_ctrl_if #(
  parameter int IN     = 8,
  parameter int I_PREC = 8,
  parameter int P_PREC = 8
);
  logic                   smp_valid;
  logic                   smp_ready;
  logic [IN*I_PREC-1:0]   smp_in;
  logic [P_PREC-1:0]      smp_train;

  modport master (output smp_valid, smp_in, smp_train, input smp_ready);
  modport slave  (input smp_valid, smp_in, smp_train, output smp_ready);
endinterface

// File: rtl/slp_train_ctrl_slp_train.sv
// Combinational perceptron update: w += rate * (train - infer) * x, saturated to the weight format.
module slp_train
  import slp_train_ctrl_pkg::*;
#(
  parameter int     IN     = 8,
  parameter dconf_t I_CONF = DEF_DCONF,
  parameter dconf_t R_CONF = DEF_DCONF,
  parameter dconf_t W_CONF = DEF_DCONF,
  parameter dconf_t P_CONF = DEF_DCONF,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int R_PREC = int'(R_CONF.prec),
  localparam int W_PREC = int'(W_CONF.prec),
  localparam int P_PREC = int'(P_CONF.prec),
  localparam int WEIGHT = IN + 1
) (
  input  logic [IN*I_PREC-1:0]     in_data,
  input  logic [R_PREC-1:0]        rate,
  input  logic [WEIGHT*W_PREC-1:0] weight,
  input  logic [P_PREC-1:0]        infer,
  input  logic [P_PREC-1:0]        train,
  output logic [WEIGHT*W_PREC-1:0] new_weight,
  output logic                     udf,
  output logic                     ovf,
  output logic                     rounded
);
  // The weight format must not carry more fraction bits than the product.
  localparam int SH = int'(R_CONF.frac) + int'(P_CONF.frac) + int'(I_CONF.frac) - int'(W_CONF.frac);
  localparam int DW = P_PREC + 1;
  localparam int PW = R_PREC + DW + I_PREC;
  localparam int SW = PW + W_PREC + 2;
  localparam logic [I_PREC-1:0] CONST1 = (I_CONF.dtype == DT_FIX) ?
                                         (I_PREC'(1) << I_CONF.frac) : I_PREC'(1);
  localparam logic signed [SW-1:0] WMAX = {{(SW-W_PREC+1){1'b0}}, {(W_PREC-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = ~WMAX;

  logic signed [DW-1:0] diff;
  logic [WEIGHT-1:0]    udf_l, ovf_l, rnd_l;

  assign diff = $signed({train[P_PREC-1], train}) - $signed({infer[P_PREC-1], infer});

  for (genvar j = 0; j < WEIGHT; j++) begin : g_lane
    logic signed [I_PREC-1:0] x;
    logic signed [W_PREC-1:0] w;
    logic signed [PW-1:0]     prod, delta;
    logic signed [SW-1:0]     sum;

    if (j == IN) begin : g_bias
      assign x = CONST1;
    end else begin : g_in
      assign x = in_data[j*I_PREC +: I_PREC];
    end

    assign w    = weight[j*W_PREC +: W_PREC];
    assign prod = PW'($signed(rate)) * PW'(diff) * PW'(x);

    if (SH > 0) begin : g_shr
      assign delta    = prod >>> SH;
      assign rnd_l[j] = |prod[SH-1:0];
    end else begin : g_noshr
      assign delta    = prod;
      assign rnd_l[j] = 1'b0;
    end

    assign sum      = SW'(w) + SW'(delta);
    assign ovf_l[j] = sum > WMAX;
    assign udf_l[j] = sum < WMIN;
    assign new_weight[j*W_PREC +: W_PREC] = ovf_l[j] ? WMAX[W_PREC-1:0] :
                                            udf_l[j] ? WMIN[W_PREC-1:0] : sum[W_PREC-1:0];
  end

  assign udf     = |udf_l;
  assign ovf     = |ovf_l;
  assign rounded = |rnd_l;
endmodule

// File: rtl/slp_train_ctrl.sv
// Sequential perceptron trainer: owns the weights, walks samples per epoch until zero errors or the epoch limit.
module slp_train_ctrl
  import slp_train_ctrl_pkg::*;
#(
  parameter int     IN        = 8,
  parameter dconf_t I_CONF    = DEF_DCONF,
  parameter dconf_t R_CONF    = DEF_DCONF,
  parameter dconf_t W_CONF    = DEF_DCONF,
  parameter dconf_t P_CONF    = DEF_DCONF,
  parameter int     SAMPLES   = 16,
  parameter int     MAX_EPOCH = 256,
  localparam int I_PREC = int'(I_CONF.prec),
  localparam int R_PREC = int'(R_CONF.prec),
  localparam int W_PREC = int'(W_CONF.prec),
  localparam int P_PREC = int'(P_CONF.prec),
  localparam int WEIGHT = IN + 1,
  localparam int SCW    = $clog2(SAMPLES),
  localparam int EPW    = max1($clog2(MAX_EPOCH))
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clr_w,
  input  logic [R_PREC-1:0]        rate,
  slp_train_ctrl_if.slave          smp,
  output logic [IN*I_PREC-1:0]     cur_in,
  input  logic [P_PREC-1:0]        infer,
  output logic [WEIGHT*W_PREC-1:0] weight,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic [EPW-1:0]           epoch,
  output logic [SCW:0]             err_cnt
);
  slp_ctrl_state_t state, state_nxt;

  logic [P_PREC-1:0]        train_q, infer_q;
  logic [SCW-1:0]           smp_cnt;
  logic [WEIGHT*W_PREC-1:0] new_weight;
  logic                     last_smp, last_epoch, err_zero;
  logic                     unused_udf, unused_ovf, unused_rnd;

  assign last_smp   = smp_cnt == SCW'(SAMPLES - 1);
  assign last_epoch = epoch == EPW'(MAX_EPOCH - 1);
  assign err_zero   = err_cnt == '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = WAIT_SMP;
      WAIT_SMP:   if (smp.smp_valid) state_nxt = EVAL;
      EVAL:       state_nxt = UPDATE;
      UPDATE:     state_nxt = last_smp ? EPOCH_END : WAIT_SMP;
      EPOCH_END:  state_nxt = (err_zero || last_epoch) ? DONE : WAIT_SMP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Ready is a pure decode of the state register, never of smp_valid.
  always_comb begin
    smp.smp_ready = state == WAIT_SMP;
    busy          = !(state == IDLE || state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weight    <= '0;
      cur_in    <= '0;
      train_q   <= '0;
      infer_q   <= '0;
      smp_cnt   <= '0;
      epoch     <= '0;
      err_cnt   <= '0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          epoch     <= '0;
          smp_cnt   <= '0;
          err_cnt   <= '0;
          done      <= 1'b0;
          converged <= 1'b0;
          if (clr_w) weight <= '0;
        end
        WAIT_SMP: if (smp.smp_valid) begin
          cur_in  <= smp.smp_in;
          train_q <= smp.smp_train;
        end
        EVAL: infer_q <= infer;
        UPDATE: begin
          weight <= new_weight;
          if (infer_q != train_q) err_cnt <= err_cnt + (SCW+1)'(1);
          smp_cnt <= last_smp ? '0 : smp_cnt + SCW'(1);
        end
        EPOCH_END: begin
          if (err_zero) begin
            converged <= 1'b1;
            done      <= 1'b1;
          end else if (last_epoch) begin
            converged <= 1'b0;
            done      <= 1'b1;
          end else begin
            epoch   <= epoch + EPW'(1);
            err_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  slp_train #(
    .IN(IN), .I_CONF(I_CONF), .R_CONF(R_CONF), .W_CONF(W_CONF), .P_CONF(P_CONF)
  ) u_train (
    .in_data   (cur_in),
    .rate      (rate),
    .weight    (weight),
    .infer     (infer_q),
    .train     (train_q),
    .new_weight(new_weight),
    .udf       (unused_udf),
    .ovf       (unused_ovf),
    .rounded   (unused_rnd)
  );
endmodule

// File: tb/tb_slp_train_ctrl.sv
// Directed bench: AND training (back-to-back and gapped), restart, reset in flight, XOR epoch limit.
module tb_slp_train_ctrl;
  import slp_train_ctrl_pkg::*;

  typedef struct {
    logic [7:0] x0, x1, lbl;
    int w0, w1, b, err, ep;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, clr_w;
  logic [7:0]  rate;
  logic [15:0] cur_in_a, cur_in_b;
  logic [23:0] weight_a, weight_b;
  logic [7:0]  infer_a, infer_b;
  logic        busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  logic [7:0]  epoch_a;
  logic [1:0]  epoch_b;
  logic [2:0]  err_a, err_b;

  int  checks = 0, errors = 0;
  time t_acc = 0;
  vec_t tv[24];

  slp_train_ctrl_if #(.IN(2), .I_PREC(8), .P_PREC(8)) smp_a ();
  slp_train_ctrl_if #(.IN(2), .I_PREC(8), .P_PREC(8)) smp_b ();

  slp_train_ctrl #(.IN(2), .SAMPLES(4), .MAX_EPOCH(256)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .clr_w(clr_w), .rate(rate), .smp(smp_a),
    .cur_in(cur_in_a), .infer(infer_a), .weight(weight_a), .busy(busy_a), .done(done_a),
    .converged(conv_a), .epoch(epoch_a), .err_cnt(err_a));

  slp_train_ctrl #(.IN(2), .SAMPLES(4), .MAX_EPOCH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .clr_w(clr_w), .rate(rate), .smp(smp_b),
    .cur_in(cur_in_b), .infer(infer_b), .weight(weight_b), .busy(busy_b), .done(done_b),
    .converged(conv_b), .epoch(epoch_b), .err_cnt(err_b));

  // External inference datapath: step(w0*x0 + w1*x1 + b > 0).
  function automatic logic [7:0] step(input logic [15:0] x, input logic [23:0] w);
    int s;
    s = $signed(w[7:0]) * $signed(x[7:0]) + $signed(w[15:8]) * $signed(x[15:8]) + $signed(w[23:16]);
    return (s > 0) ? 8'd1 : 8'd0;
  endfunction

  assign infer_a = step(cur_in_a, weight_a);
  assign infer_b = step(cur_in_b, weight_b);

  function automatic int wc(input logic [23:0] w, input int j);
    return int'($signed(w[j*8 +: 8]));
  endfunction

  function automatic vec_t mk(input int x0, x1, l, w0, w1, b, e, ep);
    vec_t v;
    v.x0 = 8'(x0); v.x1 = 8'(x1); v.lbl = 8'(l);
    v.w0 = w0; v.w1 = w1; v.b = b; v.err = e; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one sample to DUT A; check latency, hold and post-update state.
  task automatic send_a(input vec_t v, input int gap, input bit tp);
    logic [23:0] wb;
    int n;
    repeat (gap) tick();
    smp_a.smp_valid = 1'b1; smp_a.smp_in = {v.x1, v.x0}; smp_a.smp_train = v.lbl;
    n = 0;
    while (!smp_a.smp_ready && n < 50) begin tick(); n++; end
    if (!smp_a.smp_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready stayed low for %0d cycles", n);
      smp_a.smp_valid = 1'b0;
      return;
    end
    wb = weight_a;
    tick();
    smp_a.smp_valid = 1'b0;
    if (tp) chk("throughput", int'(($time - t_acc) / 10), 3);
    t_acc = $time;
    chk("eval_ready", smp_a.smp_ready, 0);
    chk("eval_busy", busy_a, 1);
    chk("cur_in", cur_in_a, {16'h0, v.x1, v.x0});
    tick();
    chk("w_hold_eval", weight_a, wb);
    tick();
    chk("w0", wc(weight_a, 0), v.w0);
    chk("w1", wc(weight_a, 1), v.w1);
    chk("bias", wc(weight_a, 2), v.b);
    chk("err_cnt", err_a, v.err);
    chk("epoch", epoch_a, v.ep);
  endtask

  task automatic send_b(input int x0, x1, l);
    int n;
    smp_b.smp_valid = 1'b1; smp_b.smp_in = {8'(x1), 8'(x0)}; smp_b.smp_train = 8'(l);
    n = 0;
    while (!smp_b.smp_ready && n < 50) begin tick(); n++; end
    if (!smp_b.smp_ready) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout: ready stayed low for %0d cycles", n);
    end else tick();
    smp_b.smp_valid = 1'b0;
  endtask

  task automatic pulse_start_a(input logic cw);
    start_a = 1'b1; clr_w = cw;
    tick();
    start_a = 1'b0; clr_w = 1'b0;
  endtask

  task automatic check_final_a(input string tag, input int ep);
    chk({tag, "_done_late"}, done_a, 0);
    tick();
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_conv"}, conv_a, 1);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_epoch"}, epoch_a, ep);
    chk({tag, "_err"}, err_a, 0);
  endtask

  initial begin
    vec_t v;
    int n;
    // AND, samples in order (0,0),(0,1),(1,0),(1,1); expected weights/err/epoch after each update.
    tv[0]  = mk(0,0,0, 0,0,0, 0,0);  tv[1]  = mk(0,1,0, 0,0,0, 0,0);
    tv[2]  = mk(1,0,0, 0,0,0, 0,0);  tv[3]  = mk(1,1,1, 1,1,1, 1,0);
    tv[4]  = mk(0,0,0, 1,1,0, 1,1);  tv[5]  = mk(0,1,0, 1,0,-1, 2,1);
    tv[6]  = mk(1,0,0, 1,0,-1, 2,1); tv[7]  = mk(1,1,1, 2,1,0, 3,1);
    tv[8]  = mk(0,0,0, 2,1,0, 0,2);  tv[9]  = mk(0,1,0, 2,0,-1, 1,2);
    tv[10] = mk(1,0,0, 1,0,-2, 2,2); tv[11] = mk(1,1,1, 2,1,-1, 3,2);
    tv[12] = mk(0,0,0, 2,1,-1, 0,3); tv[13] = mk(0,1,0, 2,1,-1, 0,3);
    tv[14] = mk(1,0,0, 1,1,-2, 1,3); tv[15] = mk(1,1,1, 2,2,-1, 2,3);
    tv[16] = mk(0,0,0, 2,2,-1, 0,4); tv[17] = mk(0,1,0, 2,1,-2, 1,4);
    tv[18] = mk(1,0,0, 2,1,-2, 1,4); tv[19] = mk(1,1,1, 2,1,-2, 1,4);
    tv[20] = mk(0,0,0, 2,1,-2, 0,5); tv[21] = mk(0,1,0, 2,1,-2, 0,5);
    tv[22] = mk(1,0,0, 2,1,-2, 0,5); tv[23] = mk(1,1,1, 2,1,-2, 0,5);

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; clr_w = 1'b0; rate = 8'd1;
    smp_a.smp_valid = 1'b0; smp_a.smp_in = '0; smp_a.smp_train = '0;
    smp_b.smp_valid = 1'b0; smp_b.smp_in = '0; smp_b.smp_train = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_weight", weight_a, 0);
    chk("rst_cur_in", cur_in_a, 0);
    chk("rst_ready", smp_a.smp_ready, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_conv", conv_a, 0);
    chk("rst_epoch", epoch_a, 0);
    chk("rst_err", err_a, 0);

    // Start with no sample offered: parks in WAIT_SMP.
    pulse_start_a(1'b1);
    repeat (3) tick();
    chk("wait_ready", smp_a.smp_ready, 1);
    chk("wait_busy", busy_a, 1);
    chk("wait_epoch", epoch_a, 0);

    for (int i = 0; i < 24; i++) send_a(tv[i], 0, (i % 4) != 0);
    check_final_a("and", 5);

    // Restart without clearing; a start while busy must not clear weights.
    pulse_start_a(1'b0);
    chk("rs_busy", busy_a, 1);
    chk("rs_done_clr", done_a, 0);
    chk("rs_bias", wc(weight_a, 2), -2);
    pulse_start_a(1'b1);
    chk("busy_start_w0", wc(weight_a, 0), 2);
    chk("busy_start_bias", wc(weight_a, 2), -2);
    chk("busy_start_ready", smp_a.smp_ready, 1);
    for (int i = 20; i < 24; i++) begin
      v = tv[i]; v.ep = 0;
      send_a(v, 0, 1'b0);
    end
    check_final_a("restart", 0);

    // Gapped source: one valid roughly every 5 cycles.
    pulse_start_a(1'b1);
    chk("clr_w_weight", weight_a, 0);
    for (int i = 0; i < 24; i++) send_a(tv[i], 2, 1'b0);
    check_final_a("gap", 5);

    // Reset while a sample sits in EVAL.
    pulse_start_a(1'b0);
    smp_a.smp_valid = 1'b1; smp_a.smp_in = 16'h0101; smp_a.smp_train = 8'd1;
    tick();
    smp_a.smp_valid = 1'b0;
    chk("pre_rst_cur_in", cur_in_a, 16'h0101);
    chk("pre_rst_busy", busy_a, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_eval_weight", weight_a, 0);
    chk("rst_eval_cur_in", cur_in_a, 0);
    chk("rst_eval_busy", busy_a, 0);
    chk("rst_eval_ready", smp_a.smp_ready, 0);
    chk("rst_eval_done", done_a, 0);
    reset = 1'b1; start_a = 1'b1;
    tick();
    reset = 1'b0; start_a = 1'b0;
    tick();
    chk("rst_start_busy", busy_a, 0);
    chk("rst_start_ready", smp_a.smp_ready, 0);

    // XOR cannot converge: stops at the epoch limit.
    start_b = 1'b1; clr_w = 1'b1;
    tick();
    start_b = 1'b0; clr_w = 1'b0;
    for (int e = 0; e < 4; e++) begin
      send_b(0, 0, 0); send_b(0, 1, 1); send_b(1, 0, 1); send_b(1, 1, 0);
    end
    n = 0;
    while (!done_b && n < 20) begin tick(); n++; end
    chk("xor_done", done_b, 1);
    chk("xor_conv", conv_b, 0);
    chk("xor_epoch", epoch_b, 3);
    chk("xor_err", err_b, 4);
    chk("xor_w0", wc(weight_b, 0), -1);
    chk("xor_w1", wc(weight_b, 1), 0);
    chk("xor_bias", wc(weight_b, 2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
